// File: rtl/power_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : power_monitor
//  Purpose  : Switching-activity monitor. It samples N_NETS gate outputs once
//             per clock and counts the 0<->1 transitions between consecutive
//             samples. It also accumulates a saturating energy estimate,
//             weighted by PWR_C_UNITS, over a start/stop window.
//  Ports    : clk      - rising-edge clock
//             reset    - synchronous, active-high
//             nets     - monitored nets (N_NETS bits, synchronous to clk)
//             start    - open a window (sampled in IDLE/DONE)
//             stop     - close the window (sampled in ARM/RUN)
//             busy     - high in ARM and RUN
//             done     - high in DONE, results held
//             toggles  - transitions counted in the window (CNT_W bits)
//             energy   - accumulated energy in 1e-6 units (ACC_W bits)
//             overflow - sticky; toggles or energy saturated
//  Revision : 1.0 - initial release
// ============================================================================
module power_monitor #(
  parameter int N_NETS      = 4,
  parameter int CNT_W       = 16,
  parameter int ACC_W       = 24,
  parameter int PWR_C_UNITS = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_NETS-1:0] nets,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  toggles,
  output logic [ACC_W-1:0]  energy,
  output logic              overflow
);

  // Per-sample transition count width, and the widths of the weighted
  // product and of the pre-saturation sums. The extra top bit on each sum
  // catches a carry past the accumulator width.
  localparam int D_W  = $clog2(N_NETS + 1);
  localparam int K_W  = (PWR_C_UNITS > 1) ? $clog2(PWR_C_UNITS + 1) : 1;
  localparam int P_W  = D_W + K_W;
  localparam int TS_W = ((CNT_W > D_W) ? CNT_W : D_W) + 1;
  localparam int ES_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_NETS-1:0] prev;
  logic [N_NETS-1:0] diff;
  logic [D_W-1:0]    d;
  logic [P_W-1:0]    prod;
  logic [TS_W-1:0]   tsum;
  logic [ES_W-1:0]   esum;
  logic              tsat;
  logic              esat;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic. start takes priority in IDLE/DONE; stop in ARM
  // skips RUN entirely, so the window closes with zero counts.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARM;
      S_ARM:   state_nxt = stop ? S_DONE : S_RUN;
      S_RUN:   if (stop) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_ARM;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transition count and weighted energy for the current sample
  // ---------------------------------------------------------------------------
  assign diff = nets ^ prev;

  always_comb begin
    d = '0;
    for (int i = 0; i < N_NETS; i++) begin
      d = d + D_W'(diff[i]);
    end
  end

  // Constant multiply, performed at full width before accumulation.
  assign prod = P_W'(d) * P_W'(PWR_C_UNITS);

  assign tsum = TS_W'(toggles) + TS_W'(d);
  assign esum = ES_W'(energy) + ES_W'(prod);
  assign tsat = |tsum[TS_W-1:CNT_W];
  assign esat = |esum[ES_W-1:ACC_W];

  // ---------------------------------------------------------------------------
  // Sample register and accumulators
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      toggles  <= '0;
      energy   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            toggles  <= '0;
            energy   <= '0;
            overflow <= 1'b0;
          end
        end
        S_ARM: begin
          // Baseline sample only; the first transition is counted in RUN.
          prev <= nets;
        end
        S_RUN: begin
          prev     <= nets;
          toggles  <= tsat ? {CNT_W{1'b1}} : tsum[CNT_W-1:0];
          energy   <= esat ? {ACC_W{1'b1}} : esum[ACC_W-1:0];
          overflow <= overflow | tsat | esat;
        end
        default: begin
          prev <= prev;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register, so they are
  // registered with respect to every input.
  assign busy = (state == S_ARM) || (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_power_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_power_monitor
//  Purpose  : Self-checking bench for power_monitor. A default instance
//             (16-bit counter, 24-bit accumulator) and a narrow instance
//             (4-bit counter, 8-bit accumulator) share all inputs and are
//             checked against a window-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_power_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [3:0]  nets;

  logic        busy, done, overflow;
  logic [15:0] toggles;
  logic [23:0] energy;

  logic        busy2, done2, overflow2;
  logic [3:0]  toggles2;
  logic [7:0]  energy2;

  int checks   = 0;
  int failures = 0;

  logic [3:0] samp[$];

  logic [42:0] act1;
  logic [14:0] act2;
  assign act1 = {busy, done, toggles, energy, overflow};
  assign act2 = {busy2, done2, toggles2, energy2, overflow2};

  always #5 clk = ~clk;

  power_monitor #(.N_NETS(4), .CNT_W(16), .ACC_W(24), .PWR_C_UNITS(30)) dut (
    .clk(clk), .reset(reset), .nets(nets), .start(start), .stop(stop),
    .busy(busy), .done(done), .toggles(toggles), .energy(energy),
    .overflow(overflow)
  );

  power_monitor #(.N_NETS(4), .CNT_W(4), .ACC_W(8), .PWR_C_UNITS(30)) dut_narrow (
    .clk(clk), .reset(reset), .nets(nets), .start(start), .stop(stop),
    .busy(busy2), .done(done2), .toggles(toggles2), .energy(energy2),
    .overflow(overflow2)
  );

  // Model: given the flags and the true (unbounded) transition total of the
  // window, the outputs are the clamped totals plus an overflow flag. The
  // overflow flag is set once either true value exceeds its register range.
  function automatic logic [42:0] exp1(input bit b, input bit dn, input longint tot);
    longint e;
    e = tot * 30;
    return {b, dn, 16'((tot > 65535) ? 65535 : tot),
            24'((e > 16777215) ? 16777215 : e),
            ((tot > 65535) || (e > 16777215))};
  endfunction

  function automatic logic [14:0] exp2(input bit b, input bit dn, input longint tot);
    longint e;
    e = tot * 30;
    return {b, dn, 4'((tot > 15) ? 15 : tot), 8'((e > 255) ? 255 : e),
            ((tot > 15) || (e > 255))};
  endfunction

  // Runs one window from IDLE or DONE: start, baseline, then the samples in
  // samp with stop on the last one. Outputs are checked after every edge.
  task automatic run_window(input logic [3:0] base, input bit stop_in_arm,
                            input bit poke_start, input string tag);
    longint     total;
    logic [3:0] pm;
    bit         last;
    total = 0;
    start = 1'b1;
    stop  = 1'($urandom_range(0, 1));
    nets  = 4'($urandom);
    @(posedge clk); #1;
    checks++;
    if (act1 !== exp1(1, 0, 0)) begin
      failures++;
      $display("FAIL %s_arm dut: got=%h want=%h", tag, act1, exp1(1, 0, 0));
    end
    checks++;
    if (act2 !== exp2(1, 0, 0)) begin
      failures++;
      $display("FAIL %s_arm narrow: got=%h want=%h", tag, act2, exp2(1, 0, 0));
    end
    start = 1'b0;
    nets  = base;
    stop  = stop_in_arm;
    @(posedge clk); #1;
    if (stop_in_arm) begin
      checks++;
      if (act1 !== exp1(0, 1, 0)) begin
        failures++;
        $display("FAIL %s_armstop dut: got=%h want=%h", tag, act1, exp1(0, 1, 0));
      end
      checks++;
      if (act2 !== exp2(0, 1, 0)) begin
        failures++;
        $display("FAIL %s_armstop narrow: got=%h want=%h", tag, act2, exp2(0, 1, 0));
      end
      stop = 1'b0;
      return;
    end
    pm = base;
    for (int i = 0; i < samp.size(); i++) begin
      last  = (i == samp.size() - 1);
      nets  = samp[i];
      stop  = last;
      start = poke_start ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      total += $countones(samp[i] ^ pm);
      pm = samp[i];
      checks++;
      if (act1 !== exp1(!last, last, total)) begin
        failures++;
        $display("FAIL %s_run[%0d] dut: got=%h want=%h", tag, i, act1,
                 exp1(!last, last, total));
      end
      checks++;
      if (act2 !== exp2(!last, last, total)) begin
        failures++;
        $display("FAIL %s_run[%0d] narrow: got=%h want=%h", tag, i, act2,
                 exp2(!last, last, total));
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; nets = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act1 !== 43'd0) begin
      failures++;
      $display("FAIL reset_init dut: got=%h want=0", act1);
    end
    checks++;
    if (act2 !== 15'd0) begin
      failures++;
      $display("FAIL reset_init narrow: got=%h want=0", act2);
    end
    reset = 1'b0;
    // Open a window and accumulate 5 transitions, then reset mid-RUN.
    start = 1'b1;                 @(posedge clk); #1;
    start = 1'b0; nets = 4'b0000; @(posedge clk); #1;
    nets = 4'b1111;               @(posedge clk); #1;
    nets = 4'b0111;               @(posedge clk); #1;
    checks++;
    if (act1 !== exp1(1, 0, 5)) begin
      failures++;
      $display("FAIL reset_prewin dut: got=%h want=%h", act1, exp1(1, 0, 5));
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (act1 !== 43'd0) begin
      failures++;
      $display("FAIL reset_midrun dut: got=%h want=0", act1);
    end
    checks++;
    if (act2 !== 15'd0) begin
      failures++;
      $display("FAIL reset_midrun narrow: got=%h want=0", act2);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_net();
    samp.delete();
    for (int i = 0; i < 10; i++) samp.push_back((i % 2 == 0) ? 4'b0001 : 4'b0000);
    run_window(4'b0000, 1'b0, 1'b0, "single");
    checks++;
    if ({done, toggles, energy} !== {1'b1, 16'd10, 24'd300}) begin
      failures++;
      $display("FAIL single_result: got done=%b toggles=%0d energy=%0d want 1/10/300",
               done, toggles, energy);
    end
  endtask

  task automatic test_multi_net();
    samp = '{4'b1111, 4'b0101, 4'b0101, 4'b1010};
    run_window(4'b0000, 1'b0, 1'b0, "multi");
    checks++;
    if ({done, toggles, energy} !== {1'b1, 16'd10, 24'd300}) begin
      failures++;
      $display("FAIL multi_result: got done=%b toggles=%0d energy=%0d want 1/10/300",
               done, toggles, energy);
    end
  endtask

  task automatic test_saturation();
    samp = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    run_window(4'b0000, 1'b0, 1'b0, "sat");
    checks++;
    if ({toggles2, energy2, overflow2} !== {4'hf, 8'hff, 1'b1}) begin
      failures++;
      $display("FAIL sat_narrow: got toggles=%0d energy=%0d ovf=%b want 15/255/1",
               toggles2, energy2, overflow2);
    end
    checks++;
    if ({toggles, energy, overflow} !== {16'd20, 24'd600, 1'b0}) begin
      failures++;
      $display("FAIL sat_wide: got toggles=%0d energy=%0d ovf=%b want 20/600/0",
               toggles, energy, overflow);
    end
  endtask

  // Restart straight from DONE; the ARM checks inside run_window also
  // confirm that the sticky overflow from the previous window is cleared.
  task automatic test_back_to_back();
    for (int w = 0; w < 2; w++) begin
      samp.delete();
      for (int i = 0; i < 3; i++) samp.push_back(4'($urandom));
      run_window(4'($urandom), 1'b0, 1'b0, "b2b");
    end
  endtask

  task automatic test_handshakes();
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (act1 !== exp1(1, 0, 0)) begin
      failures++;
      $display("FAIL hs_startstop dut: got=%h want=%h", act1, exp1(1, 0, 0));
    end
    start = 1'b0; stop = 1'b1; nets = 4'($urandom);
    @(posedge clk); #1;
    checks++;
    if (act1 !== exp1(0, 1, 0)) begin
      failures++;
      $display("FAIL hs_armstop dut: got=%h want=%h", act1, exp1(0, 1, 0));
    end
    stop = 1'b0;
    run_window(4'($urandom), 1'b1, 1'b0, "hs_arm");
    samp.delete();
    for (int i = 0; i < 8; i++) samp.push_back(4'($urandom));
    run_window(4'($urandom), 1'b0, 1'b1, "hs_runstart");
  endtask

  // Two-net chain: net0 = NAND(q,1) = ~q, net1 = NOT(net0) = q, with q a
  // register toggling every cycle. Each sample moves both nets.
  task automatic test_gate_chain();
    logic q;
    q = 1'b0;
    samp.delete();
    for (int i = 0; i < 12; i++) begin
      q = ~q;
      samp.push_back({2'b00, q, ~q});
    end
    run_window(4'b0001, 1'b0, 1'b0, "gate");
    checks++;
    if (toggles !== 16'd24) begin
      failures++;
      $display("FAIL gate_toggles: got=%0d want=24", toggles);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 12; w++) begin
      samp.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) samp.push_back(4'($urandom));
      run_window(4'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_single_net();
    test_multi_net();
    test_saturation();
    test_back_to_back();
    test_handshakes();
    test_gate_chain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
